fetch_queue: RTL

Instruction-fetch stage sitting directly downstream of the program counter register and upstream of decode. Consumes the current PC, runs a single-outstanding read handshake to instruction memory, and buffers returned instructions with their PC+1 in a small FIFO. The FIFO head is presented to decode. Drives the PC's stall input so the PC advances only when an instruction is captured or a branch redirect is applied.

---
 rtl/fetch_queue_if.sv | 22 ++
 rtl/fetch_queue.sv | 115 +++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Instruction-memory read bus between the fetch stage (master) and instruction memory (slave).
// One request is outstanding at a time; the response is a single-cycle mem_rdy pulse.
interface fetch_queue_if;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_rdy;
  logic [15:0] mem_data;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdy,
    input  mem_data
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdy,
    output mem_data
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: single-outstanding instruction read plus a small FIFO of {instr, pc+1} feeding
// decode. Gates the PC so it only advances on a captured instruction or a branch redirect.
module fetch_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          pc,
  input  logic                 flush,
  fetch_queue_if.master        mem,
  output logic                 pc_stall,
  output logic                 if_id_valid,
  output logic [15:0]          if_id_instr,
  output logic [15:0]          if_id_npc,
  input  logic                 id_stall
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetchState_t;

  fetchState_t     state;
  logic [15:0]     reqAddr;
  logic [CntW-1:0] count;
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [15:0]     instrMem [DEPTH];
  logic [15:0]     npcMem   [DEPTH];

  logic issue;
  logic push;
  logic pop;

  assign issue = (state == StIdle) & ~flush & (count < Full);
  assign push  = (state == StWait) & mem.mem_rdy & ~flush;
  assign pop   = if_id_valid & ~id_stall & ~flush;

  // Reset gating keeps the bus quiet and the PC frozen while rst_n is low.
  assign mem.mem_rd   = issue & rst_n;
  assign mem.mem_addr = pc;
  assign pc_stall     = ~((push | flush) & rst_n);

  assign if_id_valid = (count != '0);
  assign if_id_instr = instrMem[rdPtr];
  assign if_id_npc   = npcMem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StIdle;
      reqAddr <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (issue) begin
            state   <= StWait;
            reqAddr <= pc;
          end
        end
        StWait: begin
          // A response that lands with a flush is consumed and dropped here; moving to StDrop
          // would wait for a second response that memory never sends.
          if (mem.mem_rdy) begin
            state <= StIdle;
          end else if (flush) begin
            state <= StDrop;
          end
        end
        StDrop: begin
          if (mem.mem_rdy) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      if (push && !pop) begin
        count <= count + CntW'(1);
      end else if (pop && !push) begin
        count <= count - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= mem.mem_data;
      npcMem[wrPtr]   <= reqAddr + 16'd1;
    end
  end

endmodule
